hazard_forward_ctrl: RTL and testbench

//   Pipeline hazard/forwarding controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).

---
 rtl/rv32i_pkg.sv | 34 +++
 rtl/hazard_forward_ctrl_if.sv | 37 +++
 rtl/hazard_stage_reg.sv | 36 +++
 rtl/hazard_forward_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_forward_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the hazard/forwarding controller.
// Contents:
//   - the opcode values the controller decodes
//   - the EX operand source select encoding
//   - writes_rd(): whether an opcode writes a destination register
package rv32i_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // EX operand source: register file, MEM-stage result or WB-stage result
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   // BRANCH, STORE and anything not decoded never produce a register result
   function automatic logic writes_rd(input logic [6:0] opcode);
      case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
         OPC_LOAD, OPC_OPIMM, OPC_OP: writes_rd = 1'b1;
         default:                     writes_rd = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Bus between the ID-stage decode logic and the hazard/forwarding controller.
// Ports:
//   master: drives hold, flush and the ID-stage fields; observes stall/bubble,
//           the EX operand selects and the stall counter
//   slave : the controller side, the reverse directions
interface hazard_forward_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic              hold;
   logic              flush;
   logic              id_valid;
   logic [6:0]        id_opcode;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_rs1_used;
   logic              id_rs2_used;
   logic [REG_AW-1:0] id_rd;
   logic              stall;
   logic              bubble;
   logic [1:0]        fwd_sel_rs1;
   logic [1:0]        fwd_sel_rs2;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output hold, flush, id_valid, id_opcode, id_rs1, id_rs2,
             id_rs1_used, id_rs2_used, id_rd,
      input  stall, bubble, fwd_sel_rs1, fwd_sel_rs2, stall_cnt
   );

   modport slave (
      input  hold, flush, id_valid, id_opcode, id_rs1, id_rs2,
             id_rs1_used, id_rs2_used, id_rd,
      output stall, bubble, fwd_sel_rs1, fwd_sel_rs2, stall_cnt
   );

endinterface

// File: rtl/hazard_stage_reg.sv
// Shadow register for one pipeline stage: valid, rd and opcode of the
// instruction occupying that stage.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   hold                keep the current contents
//   kill                load an empty (invalid) slot instead of valid_d
//   valid_d/rd_d/opcode_d   contents of the previous stage
//   valid_q/rd_q/opcode_q   contents of this stage
module hazard_stage_reg #(
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              kill,
   input  logic              valid_d,
   input  logic [REG_AW-1:0] rd_d,
   input  logic [6:0]        opcode_d,
   output logic              valid_q,
   output logic [REG_AW-1:0] rd_q,
   output logic [6:0]        opcode_q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         rd_q     <= '0;
         opcode_q <= '0;
      end else if (!hold) begin
         valid_q  <= valid_d & ~kill;
         rd_q     <= rd_d;
         opcode_q <= opcode_d;
      end
   end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline.
// Shadows the instructions in EX, MEM and WB, detects RAW hazards against the
// ID-stage sources, registers the EX operand source selects and raises the
// one-cycle load-use stall/bubble. Counts load-use stall cycles (saturating).
// Ports:
//   clk    core clock
//   rst_n  synchronous active-low reset
//   bus    slave side of hazard_forward_ctrl_if (hold, flush, ID fields in;
//          stall, bubble, fwd_sel_rs1/rs2, stall_cnt out)
module hazard_forward_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hazard_forward_ctrl_if.slave bus
);
   import rv32i_pkg::*;

   logic              ex_valid, mem_valid, wb_valid;
   logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
   logic [6:0]        ex_opcode, mem_opcode, wb_opcode;
   logic              ex_wr, mem_wr;
   logic              load_use;
   logic              ex_kill;
   fwd_sel_e          sel_rs1_d, sel_rs2_d;
   fwd_sel_e          sel_rs1_q, sel_rs2_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              unused_wb;

   // A source picks the youngest in-flight producer; the WB stage needs no
   // select because the register file writes before it is read.
   function automatic fwd_sel_e pick_src(
      input logic              used,
      input logic [REG_AW-1:0] rs,
      input logic              ex_w,
      input logic [REG_AW-1:0] ex_r,
      input logic              mem_w,
      input logic [REG_AW-1:0] mem_r
   );
      if (used && rs != '0 && ex_w && rs == ex_r)
         pick_src = FWD_MEM;
      else if (used && rs != '0 && mem_w && rs == mem_r)
         pick_src = FWD_WB;
      else
         pick_src = FWD_RF;
   endfunction

   hazard_stage_reg #(.REG_AW(REG_AW)) u_ex (
      .clk(clk), .rst_n(rst_n), .hold(bus.hold), .kill(ex_kill),
      .valid_d(bus.id_valid), .rd_d(bus.id_rd), .opcode_d(bus.id_opcode),
      .valid_q(ex_valid), .rd_q(ex_rd), .opcode_q(ex_opcode)
   );

   hazard_stage_reg #(.REG_AW(REG_AW)) u_mem (
      .clk(clk), .rst_n(rst_n), .hold(bus.hold), .kill(1'b0),
      .valid_d(ex_valid), .rd_d(ex_rd), .opcode_d(ex_opcode),
      .valid_q(mem_valid), .rd_q(mem_rd), .opcode_q(mem_opcode)
   );

   hazard_stage_reg #(.REG_AW(REG_AW)) u_wb (
      .clk(clk), .rst_n(rst_n), .hold(bus.hold), .kill(1'b0),
      .valid_d(mem_valid), .rd_d(mem_rd), .opcode_d(mem_opcode),
      .valid_q(wb_valid), .rd_q(wb_rd), .opcode_q(wb_opcode)
   );

   // The WB shadow is kept for completeness of the tracking pipe but nothing
   // downstream consumes it.
   assign unused_wb = ^{wb_valid, wb_rd, wb_opcode};

   // Load-use detection. A flush wins over the stall because the consumer is
   // being discarded anyway.
   always_comb begin
      ex_wr    = ex_valid & writes_rd(ex_opcode) & (ex_rd != '0);
      mem_wr   = mem_valid & writes_rd(mem_opcode) & (mem_rd != '0);
      load_use = bus.id_valid & ~bus.flush & ex_wr & (ex_opcode == OPC_LOAD) &
                 ((bus.id_rs1_used & (bus.id_rs1 == ex_rd)) |
                  (bus.id_rs2_used & (bus.id_rs2 == ex_rd)));
      ex_kill  = load_use | bus.flush;
   end

   // Selects are decided in ID; an empty EX slot always gets the regfile
   // source so a bubble never steers a stale operand.
   always_comb begin
      sel_rs1_d = FWD_RF;
      sel_rs2_d = FWD_RF;
      if (bus.id_valid && !ex_kill) begin
         sel_rs1_d = pick_src(bus.id_rs1_used, bus.id_rs1, ex_wr, ex_rd, mem_wr, mem_rd);
         sel_rs2_d = pick_src(bus.id_rs2_used, bus.id_rs2, ex_wr, ex_rd, mem_wr, mem_rd);
      end
   end

   // Selects travel with the instruction into EX; the counter only advances
   // on cycles the pipeline actually stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_rs1_q <= FWD_RF;
         sel_rs2_q <= FWD_RF;
         cnt_q     <= '0;
      end else if (!bus.hold) begin
         sel_rs1_q <= sel_rs1_d;
         sel_rs2_q <= sel_rs2_d;
         if (load_use && cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + 1'b1;
      end
   end

   // Under hold the stall is masked so nothing downstream sees a phantom stall
   assign bus.stall       = load_use & ~bus.hold;
   assign bus.bubble      = load_use & ~bus.hold;
   assign bus.fwd_sel_rs1 = sel_rs1_q;
   assign bus.fwd_sel_rs2 = sel_rs2_q;
   assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed instruction sequences
// followed by randomized traffic, all compared against a behavioural model of
// the in-flight instructions.
module tb_hazard_forward_ctrl;
   import rv32i_pkg::*;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   hazard_forward_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

   hazard_forward_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         valid;
      logic [4:0] rd;
      logic [6:0] op;
   } instr_t;

   // Model: instructions occupying EX (0), MEM (1), WB (2)
   instr_t pipe [3];
   int     m_sel1, m_sel2, m_cnt;
   int     checks = 0;
   int     failures = 0;

   logic [6:0] opc_tab [10] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, 7'b1111111};

   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic bit m_produces(instr_t s);
      return s.valid && (s.op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                                      OPC_LOAD, OPC_OPIMM, OPC_OP}) && s.rd != 0;
   endfunction

   function automatic int m_src(bit used, logic [4:0] rs, bit lu);
      if (!used || rs == 0) return 0;
      if (!lu && m_produces(pipe[0]) && rs == pipe[0].rd) return 1;
      if (m_produces(pipe[1]) && rs == pipe[1].rd) return 2;
      return 0;
   endfunction

   // One clock: drive ID at negedge, compare every output with the model,
   // then advance the model over the rising edge.
   task automatic applyStimulus(input bit r, input bit h, input bit f, input bit v,
                                input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input bit u1,
                                input logic [4:0] rs2, input bit u2,
                                output bit seen_stall);
      bit lu;
      bit enters;
      @(negedge clk);
      rst_n           = r;
      bus.hold        = h;
      bus.flush       = f;
      bus.id_valid    = v;
      bus.id_opcode   = op;
      bus.id_rd       = rd;
      bus.id_rs1      = rs1;
      bus.id_rs1_used = u1;
      bus.id_rs2      = rs2;
      bus.id_rs2_used = u2;
      #1;
      lu = v && !f && m_produces(pipe[0]) && pipe[0].op == OPC_LOAD &&
           ((u1 && rs1 == pipe[0].rd) || (u2 && rs2 == pipe[0].rd));
      seen_stall = bus.stall;
      checkOutput("stall", bus.stall, lu && !h);
      checkOutput("bubble", bus.bubble, lu && !h);
      checkOutput("fwd_sel_rs1", bus.fwd_sel_rs1, m_sel1);
      checkOutput("fwd_sel_rs2", bus.fwd_sel_rs2, m_sel2);
      checkOutput("stall_cnt", bus.stall_cnt, m_cnt);
      @(posedge clk);
      if (!r) begin
         for (int i = 0; i < 3; i++) pipe[i] = '{0, 5'd0, 7'd0};
         m_sel1 = 0;
         m_sel2 = 0;
         m_cnt  = 0;
      end else if (!h) begin
         enters = v && !lu && !f;
         m_sel1 = enters ? m_src(u1, rs1, lu) : 0;
         m_sel2 = enters ? m_src(u2, rs2, lu) : 0;
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = '{enters, rd, op};
         if (lu && m_cnt < CNT_MAX) m_cnt++;
      end
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit s;
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 5'd0, 7'd0};
      m_sel1 = 0;
      m_sel2 = 0;
      m_cnt  = 0;

      // Reset
      applyStimulus(0, 0, 0, 0, OPC_OP, 0, 0, 0, 0, 0, s);
      applyStimulus(0, 0, 0, 0, OPC_OP, 0, 0, 0, 0, 0, s);
      checkOutput("rst_fwd1", bus.fwd_sel_rs1, 0);
      checkOutput("rst_cnt", bus.stall_cnt, 0);

      // ADD x3,x1,x2 ; ADD x4,x3,x3 -> both operands from MEM
      applyStimulus(1, 0, 0, 1, OPC_OP, 3, 1, 1, 2, 1, s);
      applyStimulus(1, 0, 0, 1, OPC_OP, 4, 3, 1, 3, 1, s);
      checkOutput("addadd_stall", s, 0);
      checkOutput("addadd_fwd1", bus.fwd_sel_rs1, 1);
      checkOutput("addadd_fwd2", bus.fwd_sel_rs2, 1);

      // ADDI x5,x0,1 ; NOP ; SUB x6,x5,x0 -> rs1 from WB, rs2 regfile
      applyStimulus(1, 0, 0, 1, OPC_OPIMM, 5, 0, 1, 0, 0, s);
      applyStimulus(1, 0, 0, 1, OPC_OPIMM, 0, 0, 1, 0, 0, s);
      applyStimulus(1, 0, 0, 1, OPC_OP, 6, 5, 1, 0, 1, s);
      checkOutput("sub_fwd1", bus.fwd_sel_rs1, 2);
      checkOutput("sub_fwd2", bus.fwd_sel_rs2, 0);

      // LW x7,0(x1) ; ADD x8,x7,x2 -> one stall, then rs1 from WB
      applyStimulus(1, 0, 0, 1, OPC_LOAD, 7, 1, 1, 0, 0, s);
      applyStimulus(1, 0, 0, 1, OPC_OP, 8, 7, 1, 2, 1, s);
      checkOutput("lu_stall", s, 1);
      checkOutput("lu_bubble_fwd1", bus.fwd_sel_rs1, 0);
      applyStimulus(1, 0, 0, 1, OPC_OP, 8, 7, 1, 2, 1, s);
      checkOutput("lu_second_stall", s, 0);
      checkOutput("lu_fwd1", bus.fwd_sel_rs1, 2);
      checkOutput("lu_cnt", bus.stall_cnt, 1);

      // Load-use coinciding with flush -> no stall, empty EX
      applyStimulus(1, 0, 0, 1, OPC_LOAD, 7, 1, 1, 0, 0, s);
      applyStimulus(1, 0, 1, 1, OPC_OP, 8, 7, 1, 2, 1, s);
      checkOutput("flush_stall", s, 0);
      checkOutput("flush_fwd1", bus.fwd_sel_rs1, 0);
      checkOutput("flush_fwd2", bus.fwd_sel_rs2, 0);

      // x0 destination and non-writing producers never forward
      applyStimulus(1, 0, 0, 1, OPC_OPIMM, 0, 0, 1, 0, 0, s);
      applyStimulus(1, 0, 0, 1, OPC_OP, 9, 0, 1, 0, 1, s);
      checkOutput("x0_fwd1", bus.fwd_sel_rs1, 0);
      applyStimulus(1, 0, 0, 1, OPC_STORE, 3, 1, 1, 2, 1, s);
      applyStimulus(1, 0, 0, 1, OPC_BRANCH, 3, 1, 1, 2, 1, s);
      applyStimulus(1, 0, 0, 1, OPC_OP, 10, 3, 1, 3, 1, s);
      checkOutput("sw_beq_stall", s, 0);
      checkOutput("sw_beq_fwd1", bus.fwd_sel_rs1, 0);
      checkOutput("sw_beq_fwd2", bus.fwd_sel_rs2, 0);

      // Load-use under hold for 3 cycles, then released
      applyStimulus(1, 0, 0, 1, OPC_LOAD, 7, 1, 1, 0, 0, s);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 1, OPC_OP, 8, 7, 1, 2, 1, s);
         checkOutput("hold_stall", s, 0);
         checkOutput("hold_cnt", bus.stall_cnt, 1);
      end
      applyStimulus(1, 0, 0, 1, OPC_OP, 8, 7, 1, 2, 1, s);
      checkOutput("hold_release_stall", s, 1);
      checkOutput("hold_release_cnt", bus.stall_cnt, 2);

      // Reset in the middle of a stall
      applyStimulus(1, 0, 0, 1, OPC_LOAD, 7, 1, 1, 0, 0, s);
      applyStimulus(0, 0, 0, 1, OPC_OP, 8, 7, 1, 2, 1, s);
      checkOutput("rst_mid_stall_before", s, 1);
      applyStimulus(1, 0, 0, 1, OPC_OP, 8, 7, 1, 2, 1, s);
      checkOutput("rst_mid_stall_after", s, 0);
      checkOutput("rst_mid_cnt", bus.stall_cnt, 0);

      // Counter saturation: more stalls than the counter can hold
      for (int i = 0; i < CNT_MAX + 3; i++) begin
         applyStimulus(1, 0, 0, 1, OPC_LOAD, 7, 1, 1, 0, 0, s);
         applyStimulus(1, 0, 0, 1, OPC_OP, 8, 7, 1, 2, 1, s);
         applyStimulus(1, 0, 0, 1, OPC_OP, 8, 7, 1, 2, 1, s);
      end
      checkOutput("cnt_saturated", bus.stall_cnt, CNT_MAX);

      // Randomized traffic on a small register window to provoke hazards
      for (int i = 0; i < 2000; i++) begin
         applyStimulus($urandom_range(99) >= 2,
                       $urandom_range(99) < 10,
                       $urandom_range(99) < 8,
                       $urandom_range(99) < 85,
                       opc_tab[$urandom_range(9)],
                       5'($urandom_range(7)),
                       5'($urandom_range(7)), 1'($urandom),
                       5'($urandom_range(7)), 1'($urandom),
                       s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
